jump_field_encoder: RTL

//  Inverse of the jump-target extension: turns a 32-bit jump target address into a J-type

---
 rtl/jump_field_encoder_pkg.sv | 19 +
 rtl/jump_field_encoder_if.sv | 24 ++
 rtl/jump_field_encoder_pipe_stage.sv | 31 +++
 rtl/jump_field_encoder.sv | 84 ++++++++
 4 files changed

// File: rtl/jump_field_encoder_pkg.sv
// Shared ISA definitions for the J-type encoder: opcodes, field positions,
// jump shift amount and the word carried through the pipeline.
package jump_field_encoder_pkg;

    localparam logic [5:0] OPC_J   = 6'h02;
    localparam logic [5:0] OPC_JAL = 6'h03;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int IDX_MSB   = 25;
    localparam int JMP_SHIFT = 2;

    // err[0] misaligned, err[1] out of sign-extended range
    typedef struct packed {
        logic [1:0]  err;
        logic [31:0] instr;
    } jenc_word_t;

endpackage

// File: rtl/jump_field_encoder_if.sv
// Request/response handshake bundle of the jump field encoder.
// slave: encoder side, master: producer/consumer side.
interface jump_field_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_target;
    logic        in_link;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_err;

    modport slave (
        input  in_valid, in_target, in_link, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );

    modport master (
        output in_valid, in_target, in_link, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

endinterface

// File: rtl/jump_field_encoder_pipe_stage.sv
// Generic valid/ready register slice, WIDTH bits of payload.
// Ports: clk, rst_n, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module jump_field_encoder_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Refill in the same cycle the held word drains: no bubbles.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/jump_field_encoder.sv
// Encodes a jump target address into a J-type word {opcode, target[27:2]},
// flags targets the index extension cannot reproduce, counts errored words.
// Ports: Clk, Rst_n, bus (in_*/out_* handshake), err_clr, err_count.
module jump_field_encoder
    import jump_field_encoder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    jump_field_encoder_if.slave  bus,
    input  logic                 err_clr,
    output logic [CNT_W-1:0]     err_count
);

    localparam int IDX_LO = JMP_SHIFT;
    localparam int IDX_HI = IDX_MSB + JMP_SHIFT;
    localparam int W      = $bits(jenc_word_t);

    jenc_word_t s1_d;
    jenc_word_t s1_q;
    jenc_word_t s2_q;
    logic       s1_valid;
    logic       s2_ready;
    logic       s2_valid;
    logic       cnt_evt;
    logic [5:0] opc;

    assign opc = bus.in_link ? OPC_JAL : OPC_J;

    always_comb begin
        s1_d = '0;
        s1_d.instr[OPC_MSB:OPC_LSB] = opc;
        s1_d.instr[IDX_MSB:0] = bus.in_target[IDX_HI:IDX_LO];
        s1_d.err[0] = |bus.in_target[IDX_LO-1:0];
        // Upper bits must be the sign extension of the top index bit
        s1_d.err[1] = bus.in_target[31:IDX_HI+1]
                      != {(31-IDX_HI){bus.in_target[IDX_HI]}};
    end

    jump_field_encoder_pipe_stage #(.WIDTH(W)) u_s1 (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .in_valid (bus.in_valid),
        .in_ready (bus.in_ready),
        .in_data  (s1_d),
        .out_valid(s1_valid),
        .out_ready(s2_ready),
        .out_data (s1_q)
    );

    jump_field_encoder_pipe_stage #(.WIDTH(W)) u_s2 (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .in_valid (s1_valid),
        .in_ready (s2_ready),
        .in_data  (s1_q),
        .out_valid(s2_valid),
        .out_ready(bus.out_ready),
        .out_data (s2_q)
    );

    assign bus.out_valid = s2_valid;
    assign bus.out_instr = s2_q.instr;
    assign bus.out_err   = s2_q.err;

    assign cnt_evt = s2_valid && bus.out_ready && (|s2_q.err);

    // Clear takes effect first, so a coincident event leaves a count of one
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            err_count <= '0;
        end else if (cnt_evt) begin
            if (err_clr) begin
                err_count <= CNT_W'(1);
            end else if (err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
            end
        end else if (err_clr) begin
            err_count <= '0;
        end
    end

endmodule
